// File: rtl/icache_refill_unit.sv
// I-cache refill engine: accepts one miss, issues a line-aligned memory read,
// gathers the response beats into a full line, then writes the line into the
// victim way in a single cycle. Only one refill is outstanding at a time.
module icache_refill_unit #(
  parameter int NUM_WAYS            = 4,
  parameter int NUM_BANKS           = 4,
  parameter int SETS_PER_BANK_WIDTH = 8,
  parameter int BLOCK_WIDTH         = 512,
  parameter int BEAT_WIDTH          = 64,
  parameter int ADDR_WIDTH          = 32,
  // Derived widths; not intended to be overridden.
  parameter int BANK_W              = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           miss_valid_i,
  output logic                           miss_ready_o,
  input  logic [ADDR_WIDTH-1:0]          miss_addr_i,
  input  logic [NUM_WAYS-1:0]            miss_way_i,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr_o,
  input  logic                           mem_rsp_valid_i,
  output logic                           mem_rsp_ready_o,
  input  logic [BEAT_WIDTH-1:0]          mem_rsp_data_i,
  input  logic                           mem_rsp_last_i,
  output logic [SETS_PER_BANK_WIDTH-1:0] w_bank_addr_o,
  output logic [BANK_W-1:0]              w_bank_sel_o,
  output logic [NUM_WAYS-1:0]            we_way_mask_o,
  output logic [BLOCK_WIDTH-1:0]         wdata_o,
  output logic                           refill_done_o,
  output logic                           refill_err_o,
  output logic                           busy_o
);

  localparam int BEATS = BLOCK_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF   = $clog2(BLOCK_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RECV  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [NUM_WAYS-1:0]     way_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    err_q;
  logic [BLOCK_WIDTH-1:0]  line_q;

  // Write-port fields and request address come straight from held registers.
  assign mem_req_addr_o = addr_q;
  assign w_bank_sel_o   = addr_q[OFF +: BANK_W];
  assign w_bank_addr_o  = addr_q[OFF+BANK_W +: SETS_PER_BANK_WIDTH];
  assign wdata_o        = line_q;

  // Refill sequencer: state, datapath registers and every control output.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking would make the result order-dependent.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the line buffer is an ordinary register (not an array macro),
      // so it is cleared with everything else to keep outputs zero in reset.
      state_q         <= IDLE;
      addr_q          <= '0;
      way_q           <= '0;
      cnt_q           <= '0;
      err_q           <= 1'b0;
      line_q          <= '0;
      miss_ready_o    <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_rsp_ready_o <= 1'b0;
      we_way_mask_o   <= '0;
      refill_done_o   <= 1'b0;
      refill_err_o    <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      // Pulses and the write enable are single-cycle by default.
      refill_done_o <= 1'b0;
      refill_err_o  <= 1'b0;
      we_way_mask_o <= '0;

      case (state_q)
        IDLE: begin
          miss_ready_o <= 1'b1;
          if (miss_valid_i && miss_ready_o) begin
            addr_q            <= miss_addr_i;
            addr_q[OFF-1:0]   <= '0;
            way_q             <= miss_way_i;
            cnt_q             <= '0;
            err_q             <= 1'b0;
            miss_ready_o      <= 1'b0;
            mem_req_valid_o   <= 1'b1;
            busy_o            <= 1'b1;
            state_q           <= REQ;
          end
        end

        REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            mem_rsp_ready_o <= 1'b1;
            state_q         <= RECV;
          end
        end

        RECV: begin
          if (mem_rsp_valid_i) begin
            line_q[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rsp_data_i;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              // Full line collected; a missing last marker is flagged but the
              // line is still written.
              mem_rsp_ready_o <= 1'b0;
              we_way_mask_o   <= way_q;
              refill_done_o   <= 1'b1;
              refill_err_o    <= err_q | ~mem_rsp_last_i;
              err_q           <= err_q | ~mem_rsp_last_i;
              state_q         <= WRITE;
            end else if (mem_rsp_last_i) begin
              // Burst ended early: drop the partial line, report, go idle.
              mem_rsp_ready_o <= 1'b0;
              refill_err_o    <= 1'b1;
              err_q           <= 1'b1;
              miss_ready_o    <= 1'b1;
              busy_o          <= 1'b0;
              state_q         <= IDLE;
            end
          end
        end

        WRITE: begin
          miss_ready_o <= 1'b1;
          busy_o       <= 1'b0;
          state_q      <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed self-checking bench for icache_refill_unit (default parameters).
module tb_icache_refill_unit;

  localparam int BEATS = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         miss_valid_i = 1'b0;
  logic         miss_ready_o;
  logic [31:0]  miss_addr_i = '0;
  logic [3:0]   miss_way_i = '0;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i = 1'b0;
  logic [31:0]  mem_req_addr_o;
  logic         mem_rsp_valid_i = 1'b0;
  logic         mem_rsp_ready_o;
  logic [63:0]  mem_rsp_data_i = '0;
  logic         mem_rsp_last_i = 1'b0;
  logic [7:0]   w_bank_addr_o;
  logic [1:0]   w_bank_sel_o;
  logic [3:0]   we_way_mask_o;
  logic [511:0] wdata_o;
  logic         refill_done_o;
  logic         refill_err_o;
  logic         busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  icache_refill_unit dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .miss_valid_i    (miss_valid_i),
    .miss_ready_o    (miss_ready_o),
    .miss_addr_i     (miss_addr_i),
    .miss_way_i      (miss_way_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_ready_o (mem_rsp_ready_o),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .mem_rsp_last_i  (mem_rsp_last_i),
    .w_bank_addr_o   (w_bank_addr_o),
    .w_bank_sel_o    (w_bank_sel_o),
    .we_way_mask_o   (we_way_mask_o),
    .wdata_o         (wdata_o),
    .refill_done_o   (refill_done_o),
    .refill_err_o    (refill_err_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk_i);
  endtask

  // One complete miss. last_at: index of the beat carrying last (BEATS = never).
  // With hold2 set, a second miss (addr2/way2) stays asserted for the whole run.
  task automatic run_refill(input string nm, input logic [31:0] addr, input logic [3:0] way,
                            input int req_stall, input int gap, input int last_at,
                            input logic [63:0] base, input logic [31:0] exp_aligned,
                            input logic [1:0] exp_bank, input logic [7:0] exp_set,
                            input int exp_lat, input logic hold2,
                            input logic [31:0] addr2, input logic [3:0] way2);
    int t0;
    logic [511:0] exp_line;
    for (int k = 0; k < BEATS; k++) exp_line[k*64 +: 64] = base + 64'(k);

    check({nm, "_idle_ready"}, miss_ready_o, 1'b1);
    miss_valid_i = 1'b1; miss_addr_i = addr; miss_way_i = way; t0 = cyc;
    step();
    if (hold2) begin
      miss_addr_i = addr2; miss_way_i = way2;
    end else begin
      miss_valid_i = 1'b0;
    end
    check({nm, "_req_valid"}, mem_req_valid_o, 1'b1);
    check({nm, "_req_addr"}, mem_req_addr_o, exp_aligned);
    check({nm, "_req_not_ready"}, miss_ready_o, 1'b0);

    for (int i = 0; i < req_stall; i++) begin
      mem_req_ready_i = 1'b0;
      step();
      check({nm, "_req_hold_valid"}, mem_req_valid_o, 1'b1);
      check({nm, "_req_hold_addr"}, mem_req_addr_o, exp_aligned);
    end
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    check({nm, "_rsp_ready"}, mem_rsp_ready_o, 1'b1);
    check({nm, "_req_dropped"}, mem_req_valid_o, 1'b0);

    for (int k = 0; k < BEATS; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          mem_rsp_valid_i = 1'b0;
          step();
          check({nm, "_gap_rsp_ready"}, mem_rsp_ready_o, 1'b1);
        end
      end
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = base + 64'(k);
      mem_rsp_last_i  = (k == last_at);
      step();
      mem_rsp_valid_i = 1'b0;
      mem_rsp_last_i  = 1'b0;
      if (k == last_at && k < BEATS - 1) begin
        check({nm, "_abort_err"}, refill_err_o, 1'b1);
        check({nm, "_abort_done"}, refill_done_o, 1'b0);
        check({nm, "_abort_mask"}, we_way_mask_o, 4'b0000);
        check({nm, "_abort_ready"}, miss_ready_o, 1'b1);
        check({nm, "_abort_rsp_ready"}, mem_rsp_ready_o, 1'b0);
        step();
        check({nm, "_abort_err_pulse"}, refill_err_o, 1'b0);
        check({nm, "_abort_mask_after"}, we_way_mask_o, 4'b0000);
        return;
      end
      if (k < BEATS - 1) check({nm, "_recv_mask"}, we_way_mask_o, 4'b0000);
    end

    // Write cycle.
    check({nm, "_wr_latency"}, 32'(cyc - t0), 32'(exp_lat));
    check({nm, "_wr_mask"}, we_way_mask_o, way);
    check({nm, "_wr_done"}, refill_done_o, 1'b1);
    check({nm, "_wr_err"}, refill_err_o, (last_at != BEATS - 1));
    check({nm, "_wr_data"}, wdata_o, exp_line);
    check({nm, "_wr_bank_sel"}, w_bank_sel_o, exp_bank);
    check({nm, "_wr_bank_addr"}, w_bank_addr_o, exp_set);
    check({nm, "_wr_busy_ready"}, miss_ready_o, 1'b0);
    step();
    check({nm, "_post_ready"}, miss_ready_o, 1'b1);
    check({nm, "_post_busy"}, busy_o, 1'b0);
    check({nm, "_post_done"}, refill_done_o, 1'b0);
    check({nm, "_post_mask"}, we_way_mask_o, 4'b0000);
  endtask

  initial begin
    // Power-on reset.
    step(); step();
    check("rst_ready", miss_ready_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_req_valid", mem_req_valid_o, 1'b0);
    rst_i = 1'b0;
    step();
    check("rel_ready", miss_ready_o, 1'b1);

    // Basic refill: beats 0..7, last on beat 7, write at T+10.
    run_refill("basic", 32'h0000_1A7C, 4'b0100, 0, 0, 7, 64'h0,
               32'h0000_1A40, 2'd1, 8'h1A, 10, 1'b0, '0, '0);

    // Stalls: request held 3 cycles, one idle cycle between beats.
    run_refill("stall", 32'h0000_1A7C, 4'b0100, 3, 1, 7, 64'h0,
               32'h0000_1A40, 2'd1, 8'h1A, 20, 1'b0, '0, '0);

    // Different address/data, back-to-back.
    run_refill("alt", 32'h0000_5F83, 4'b0001, 0, 0, 7, 64'hDEAD_BEEF_0000_0100,
               32'h0000_5F80, 2'd2, 8'h5F, 10, 1'b0, '0, '0);

    // Last never asserted: line written with done and err together.
    run_refill("nolast", 32'h1234_56C0, 4'b0010, 0, 0, BEATS, 64'hA5A5_0000_0000_0010,
               32'h1234_56C0, 2'd3, 8'h56, 10, 1'b0, '0, '0);

    // Early last on beat 3: abort with no write.
    run_refill("early", 32'h0000_0010, 4'b0001, 0, 0, 3, 64'h0,
               32'h0000_0000, 2'd0, 8'h00, 0, 1'b0, '0, '0);

    // Busy rejection: second miss held throughout, accepted only afterwards.
    // The second one uses a zero way mask, which still completes.
    run_refill("busyA", 32'h0000_AB44, 4'b1000, 0, 0, 7, 64'h1111_0000_0000_0000,
               32'h0000_AB40, 2'd1, 8'hAB, 10, 1'b1, 32'h0000_CDFF, 4'b0000);
    run_refill("busyB", 32'h0000_CDFF, 4'b0000, 0, 0, 7, 64'h2222_0000_0000_0000,
               32'h0000_CDC0, 2'd3, 8'hCD, 10, 1'b0, '0, '0);

    // Reset in the middle of RECV after 4 beats.
    miss_valid_i = 1'b1; miss_addr_i = 32'h0000_3300; miss_way_i = 4'b0001;
    step();
    miss_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 64'hFFFF_0000_0000_0000 + 64'(k);
      step();
    end
    mem_rsp_valid_i = 1'b0;
    check("mid_rsp_ready", mem_rsp_ready_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check("arst_rsp_ready", mem_rsp_ready_o, 1'b0);
    check("arst_busy", busy_o, 1'b0);
    check("arst_ready", miss_ready_o, 1'b0);
    check("arst_wdata", wdata_o, '0);
    check("arst_req_addr", mem_req_addr_o, 32'h0);
    check("arst_mask", we_way_mask_o, 4'b0000);
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 64'hBAD0_BAD0_BAD0_BAD0;
    step(); step();
    rst_i = 1'b0;
    step();
    check("rel2_rsp_ready", mem_rsp_ready_o, 1'b0);
    check("rel2_mask", we_way_mask_o, 4'b0000);
    check("rel2_wdata", wdata_o, '0);
    mem_rsp_valid_i = 1'b0;
    run_refill("after_rst", 32'h0000_0077, 4'b0010, 0, 0, 7, 64'h0000_0000_C0DE_0000,
               32'h0000_0040, 2'd1, 8'h00, 10, 1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
